// File: rtl/bli201v32itl_biu_pkg.sv
// Shared TL-UL field widths, opcodes, region indices and BIU state encoding.
// Store masks map to PutFullData / PutPartialData opcodes and sizes via the helpers below.
package bli201v32itl_biu_pkg;

  localparam int TL_OPC_W     = 3;
  localparam int TL_A_PARAM_W = 3;
  localparam int TL_D_PARAM_W = 2;
  localparam int TL_SIZE_W    = 2;
  localparam int TL_SRC_W     = 8;
  localparam int TL_SINK_W    = 1;
  localparam int TL_ADDR_W    = 32;
  localparam int TL_MASK_W    = 4;
  localparam int TL_DATA_W    = 32;

  localparam int REG_ITIM = 0;
  localparam int REG_DTIM = 1;
  localparam int REG_MMIO = 2;
  localparam int REG_N    = 3;

  typedef enum logic [TL_OPC_W-1:0] {
    TL_PUT_FULL_DATA    = 3'd0,
    TL_PUT_PARTIAL_DATA = 3'd1,
    TL_GET              = 3'd4
  } tl_a_opcode_e;

  typedef enum logic [TL_OPC_W-1:0] {
    TL_ACCESS_ACK      = 3'd0,
    TL_ACCESS_ACK_DATA = 3'd1
  } tl_d_opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DONE
  } biu_state_e;

  typedef struct packed {
    tl_a_opcode_e           opcode;
    logic [TL_SIZE_W-1:0]   size;
    logic [TL_ADDR_W-1:0]   address;
    logic [TL_MASK_W-1:0]   mask;
    logic [TL_DATA_W-1:0]   data;
  } tl_a_req_t;

  function automatic tl_a_opcode_e put_opcode(input logic [TL_MASK_W-1:0] mask);
    return (mask == 4'hF) ? TL_PUT_FULL_DATA : TL_PUT_PARTIAL_DATA;
  endfunction

  // Sparse masks that are not an aligned byte/half still go out as a full-word partial put.
  function automatic logic [TL_SIZE_W-1:0] put_size(input logic [TL_MASK_W-1:0] mask);
    case (mask)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return 2'd0;
      4'b0011, 4'b1100:                   return 2'd1;
      default:                            return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/bli201v32itl_biu_decode.sv
// Combinational region decoder: one hit bit per region plus region-relative offsets.
// Regions are naturally aligned, so each offset is just the low address bits.
module bli201v32itl_biu_decode
  import bli201v32itl_biu_pkg::*;
#(
  parameter logic [31:0] ITIM_BASE = 32'h0000_0000,
  parameter int          ITIM_AW   = 12,
  parameter logic [31:0] DTIM_BASE = 32'h0000_1000,
  parameter int          DTIM_AW   = 12,
  parameter logic [31:0] MMIO_BASE = 32'h0000_2000,
  parameter int          MMIO_AW   = 12
) (
  input  logic [31:0]        addr,
  output logic [REG_N-1:0]   hit,
  output logic [ITIM_AW-1:0] itim_off,
  output logic [DTIM_AW-1:0] dtim_off,
  output logic [MMIO_AW-1:0] mmio_off
);

  localparam logic [REG_N-1:0][31:0] BASES = {MMIO_BASE, DTIM_BASE, ITIM_BASE};
  localparam logic [REG_N-1:0][31:0] AWS   = {32'(MMIO_AW), 32'(DTIM_AW), 32'(ITIM_AW)};

  generate
    for (genvar gi = 0; gi < REG_N; gi++) begin : g_hit
      localparam logic [31:0] HI_MASK = ~((32'd1 << AWS[gi]) - 32'd1);
      assign hit[gi] = (addr & HI_MASK) == BASES[gi];
    end
  endgenerate

  assign itim_off = addr[ITIM_AW-1:0];
  assign dtim_off = addr[DTIM_AW-1:0];
  assign mmio_off = addr[MMIO_AW-1:0];

endmodule

// File: rtl/bli201v32itl_biu_tlul.sv
// Bus interface unit: zero-latency ITIM/DTIM paths and a TL-UL MMIO master.
// MMIO accesses stall the core until the D response has been captured.
module bli201v32itl_biu_tlul
  import bli201v32itl_biu_pkg::*;
#(
  parameter logic [31:0] ITIM_BASE = 32'h0000_0000,
  parameter int          ITIM_AW   = 12,
  parameter logic [31:0] DTIM_BASE = 32'h0000_1000,
  parameter int          DTIM_AW   = 12,
  parameter logic [31:0] MMIO_BASE = 32'h0000_2000,
  parameter int          MMIO_AW   = 12,
  parameter int          TL_SOURCE = 0,
  parameter logic [31:0] ERR_RDATA = 32'hCCCC_CCCC
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    biu_o_halt,
  output logic                    biu_o_bus_err,
  input  logic [31:0]             biu_i_iaddr,
  output logic [31:0]             biu_o_idata,
  input  logic [31:0]             biu_i_daddr,
  input  logic                    biu_i_is_load,
  input  logic                    biu_i_is_store,
  input  logic [3:0]              biu_i_dwmask,
  input  logic [31:0]             biu_i_dwdata,
  output logic [31:0]             biu_o_drdata,
  output logic [ITIM_AW-1:0]      biu_o_itim_addr,
  input  logic [31:0]             biu_i_itim_rdata,
  output logic [DTIM_AW-1:0]      biu_o_dtim_addr,
  output logic [3:0]              biu_o_dtim_wmask,
  output logic [31:0]             biu_o_dtim_wdata,
  input  logic [31:0]             biu_i_dtim_rdata,
  output logic [TL_OPC_W-1:0]     biu_o_tl_a_opcode,
  output logic [TL_A_PARAM_W-1:0] biu_o_tl_a_param,
  output logic [TL_SIZE_W-1:0]    biu_o_tl_a_size,
  output logic [TL_SRC_W-1:0]     biu_o_tl_a_source,
  output logic [TL_ADDR_W-1:0]    biu_o_tl_a_address,
  output logic [TL_MASK_W-1:0]    biu_o_tl_a_mask,
  output logic [TL_DATA_W-1:0]    biu_o_tl_a_data,
  output logic                    biu_o_tl_a_corrupt,
  output logic                    biu_o_tl_a_valid,
  input  logic                    biu_i_tl_a_ready,
  input  logic [TL_OPC_W-1:0]     biu_i_tl_d_opcode,
  input  logic [TL_D_PARAM_W-1:0] biu_i_tl_d_param,
  input  logic [TL_SIZE_W-1:0]    biu_i_tl_d_size,
  input  logic [TL_SRC_W-1:0]     biu_i_tl_d_source,
  input  logic [TL_SINK_W-1:0]    biu_i_tl_d_sink,
  input  logic                    biu_i_tl_d_denied,
  input  logic [TL_DATA_W-1:0]    biu_i_tl_d_data,
  input  logic                    biu_i_tl_d_corrupt,
  input  logic                    biu_i_tl_d_valid,
  output logic                    biu_o_tl_d_ready
);

  localparam logic [TL_SRC_W-1:0] SRC_ID = TL_SRC_W'(TL_SOURCE);

  logic [REG_N-1:0]   d_hit;
  logic [ITIM_AW-1:0] d_itim_off;
  logic [DTIM_AW-1:0] d_dtim_off;
  logic [MMIO_AW-1:0] d_mmio_off;

  bli201v32itl_biu_decode #(
    .ITIM_BASE (ITIM_BASE),
    .ITIM_AW   (ITIM_AW),
    .DTIM_BASE (DTIM_BASE),
    .DTIM_AW   (DTIM_AW),
    .MMIO_BASE (MMIO_BASE),
    .MMIO_AW   (MMIO_AW)
  ) u_decode (
    .addr     (biu_i_daddr),
    .hit      (d_hit),
    .itim_off (d_itim_off),
    .dtim_off (d_dtim_off),
    .mmio_off (d_mmio_off)
  );

  logic access;
  logic mmio_req;
  logic unmapped_req;

  // ITIM has no data-side port (its address is owned by fetch), so data accesses there are errors.
  assign access       = biu_i_is_load | biu_i_is_store;
  assign mmio_req     = access & d_hit[REG_MMIO];
  assign unmapped_req = access & ~(d_hit[REG_DTIM] | d_hit[REG_MMIO]);

  biu_state_e state_reg;
  tl_a_req_t  a_req_reg;
  logic       a_valid_reg;
  logic       d_ready_reg;
  logic       is_store_reg;
  logic       err_reg;
  logic [31:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      a_req_reg    <= '0;
      a_valid_reg  <= 1'b0;
      d_ready_reg  <= 1'b0;
      is_store_reg <= 1'b0;
      err_reg      <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (mmio_req) begin
            a_req_reg.opcode  <= biu_i_is_store ? put_opcode(biu_i_dwmask) : TL_GET;
            a_req_reg.size    <= biu_i_is_store ? put_size(biu_i_dwmask) : 2'd2;
            a_req_reg.address <= {{(TL_ADDR_W-MMIO_AW){1'b0}}, d_mmio_off};
            a_req_reg.mask    <= biu_i_is_store ? biu_i_dwmask : 4'hF;
            a_req_reg.data    <= biu_i_is_store ? biu_i_dwdata : '0;
            is_store_reg      <= biu_i_is_store;
            a_valid_reg       <= 1'b1;
            state_reg         <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (biu_i_tl_a_ready) begin
            a_valid_reg <= 1'b0;
            d_ready_reg <= 1'b1;
            state_reg   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (biu_i_tl_d_valid) begin
            d_ready_reg <= 1'b0;
            rdata_reg   <= biu_i_tl_d_data;
            err_reg     <= biu_i_tl_d_denied | biu_i_tl_d_corrupt |
                           (biu_i_tl_d_source != SRC_ID) |
                           (is_store_reg & (biu_i_tl_d_opcode != TL_ACCESS_ACK));
            state_reg   <= ST_DONE;
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign biu_o_halt    = ((state_reg == ST_IDLE) & mmio_req) |
                         (state_reg == ST_REQ) | (state_reg == ST_RESP);
  assign biu_o_bus_err = ((state_reg == ST_DONE) & err_reg) |
                         ((state_reg == ST_IDLE) & unmapped_req);

  always_comb begin
    biu_o_drdata = ERR_RDATA;
    if (state_reg == ST_DONE) begin
      biu_o_drdata = err_reg ? ERR_RDATA : rdata_reg;
    end else if (d_hit[REG_DTIM]) begin
      biu_o_drdata = biu_i_dtim_rdata;
    end
  end

  assign biu_o_itim_addr  = biu_i_iaddr[ITIM_AW-1:0];
  assign biu_o_idata      = biu_i_itim_rdata;

  assign biu_o_dtim_addr  = d_dtim_off;
  assign biu_o_dtim_wdata = biu_i_dwdata;
  assign biu_o_dtim_wmask = (biu_i_is_store & d_hit[REG_DTIM]) ? biu_i_dwmask : 4'h0;

  assign biu_o_tl_a_opcode  = a_req_reg.opcode;
  assign biu_o_tl_a_param   = '0;
  assign biu_o_tl_a_size    = a_req_reg.size;
  assign biu_o_tl_a_source  = SRC_ID;
  assign biu_o_tl_a_address = a_req_reg.address;
  assign biu_o_tl_a_mask    = a_req_reg.mask;
  assign biu_o_tl_a_data    = a_req_reg.data;
  assign biu_o_tl_a_corrupt = 1'b0;
  assign biu_o_tl_a_valid   = a_valid_reg;
  assign biu_o_tl_d_ready   = d_ready_reg;

  logic unused_bits;
  assign unused_bits = ^{biu_i_tl_d_param, biu_i_tl_d_size, biu_i_tl_d_sink,
                         biu_i_iaddr[31:ITIM_AW], d_itim_off, d_hit[REG_ITIM]};

endmodule
